// File: rtl/data_memory_controller.sv
// Round-robin arbiter in front of an internal data memory with a fixed access latency.
// Serves one LSU read or write at a time and closes each request with a one-cycle ready pulse.
module data_memory_controller #(
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int LATENCY      = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CHANNELS-1:0]              mem_read_valid,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0]   mem_read_address,
  output logic [NUM_CHANNELS-1:0]              mem_read_ready,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]   mem_read_data,
  input  logic [NUM_CHANNELS-1:0]              mem_write_valid,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0]   mem_write_address,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   mem_write_data,
  output logic [NUM_CHANNELS-1:0]              mem_write_ready,
  output logic                                 busy
);

  localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  state_t                  state, state_next;
  logic [IDX_W-1:0]        rr_ptr, grant_idx, cand, cur_ch;
  logic                    grant_found, cur_write;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [DATA_WIDTH-1:0]   cur_data;
  logic [3:0]              count;
  logic [NUM_CHANNELS-1:0] mask, eligible;

  logic [ADDR_WIDTH-1:0]   rd_addr [NUM_CHANNELS];
  logic [ADDR_WIDTH-1:0]   wr_addr [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]   wr_data [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]   read_data_q [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    assign rd_addr[c] = mem_read_address[c*ADDR_WIDTH +: ADDR_WIDTH];
    assign wr_addr[c] = mem_write_address[c*ADDR_WIDTH +: ADDR_WIDTH];
    assign wr_data[c] = mem_write_data[c*DATA_WIDTH +: DATA_WIDTH];
    assign mem_read_data[c*DATA_WIDTH +: DATA_WIDTH] = read_data_q[c];
  end

  // The channel that just completed is masked for one arbitration cycle only.
  assign eligible = (mem_read_valid | mem_write_valid) & ~mask;

  always_comb begin
    state_next  = state;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
          cand = IDX_W'((int'(rr_ptr) + i) % NUM_CHANNELS);
          if (!grant_found && eligible[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
          end
        end
        if (grant_found) state_next = ACCESS;
      end
      ACCESS:  if (count == 4'd0) state_next = RESPOND;
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      mask            <= '0;
      cur_ch          <= '0;
      cur_write       <= 1'b0;
      cur_addr        <= '0;
      cur_data        <= '0;
      count           <= '0;
      mem_read_ready  <= '0;
      mem_write_ready <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) read_data_q[c] <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          mask <= '0;
          if (grant_found) begin
            // Read wins when both are pending; the write competes again later.
            cur_ch    <= grant_idx;
            cur_write <= !mem_read_valid[grant_idx];
            cur_addr  <= mem_read_valid[grant_idx] ? rd_addr[grant_idx] : wr_addr[grant_idx];
            cur_data  <= wr_data[grant_idx];
            count     <= 4'(LATENCY - 1);
            rr_ptr    <= (int'(grant_idx) == NUM_CHANNELS - 1) ? '0 : grant_idx + 1'b1;
          end
        end
        ACCESS: begin
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end else if (cur_write) begin
            mem_write_ready[cur_ch] <= 1'b1;
          end else begin
            mem_read_ready[cur_ch] <= 1'b1;
            read_data_q[cur_ch]    <= mem[cur_addr];
          end
        end
        RESPOND: begin
          mem_read_ready  <= '0;
          mem_write_ready <= '0;
          mask            <= '0;
          mask[cur_ch]    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Memory contents survive reset; a write aborted by reset never lands.
  always_ff @(posedge clk) begin
    if (!reset && state == ACCESS && count == 4'd0 && cur_write)
      mem[cur_addr] <= cur_data;
  end

endmodule

// File: tb/tb_data_memory_controller.sv
// Randomised and directed bench for data_memory_controller: LSU-like drivers, a timeline
// reference model that predicts every ready pulse, and a negedge monitor that scores them.
module tb_data_memory_controller;

  localparam int NC  = 4;
  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  logic [NC-1:0]    mem_read_valid, mem_read_ready, mem_write_valid, mem_write_ready;
  logic [NC*AW-1:0] mem_read_address, mem_write_address;
  logic [NC*DW-1:0] mem_read_data, mem_write_data;
  logic             busy;

  always #5 clk = ~clk;

  data_memory_controller #(
    .NUM_CHANNELS(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .busy(busy)
  );

  typedef struct {
    int            ch;
    bit            wr;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_count = 0;

  always @(posedge clk) edge_count <= edge_count + 1;

  bit            rv[NC], wv[NC], persist[NC];
  logic [AW-1:0] raddr[NC], waddr[NC];
  logic [DW-1:0] wdata[NC];

  // Reference model: grants are points on a timeline, memory is a plain array.
  logic [DW-1:0] model_mem [256];
  bit            committed [256];
  int            known_q[$];
  int            ptr = 0, next_free = 0, mask_ch = -1, mask_due = -1;
  int            busy_from = 1, busy_to = 0, grant_count = 0;
  bit            pend_valid = 1'b0;
  int            pend_due = 0;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_data;
  bit            reset_edges[int];
  logic [DW-1:0] held[NC];

  task automatic apply_stimulus();
    int   g, ch;
    bit   found;
    exp_t e;
    for (int c = 0; c < NC; c++) begin
      mem_read_valid[c]             = rv[c];
      mem_write_valid[c]            = wv[c];
      mem_read_address[c*AW +: AW]  = raddr[c];
      mem_write_address[c*AW +: AW] = waddr[c];
      mem_write_data[c*DW +: DW]    = wdata[c];
    end
    g = edge_count + 1;
    if (reset) begin
      reset_edges[g] = 1'b1;
      ptr = 0; next_free = g + 1; mask_due = -1; pend_valid = 1'b0;
      if (busy_to > g - 1) busy_to = g - 1;
      while (exp_q.size() > 0 && exp_q[$].due >= g) void'(exp_q.pop_back());
      return;
    end
    if (pend_valid && pend_due <= g) begin
      model_mem[pend_addr] = pend_data;
      if (!committed[pend_addr]) known_q.push_back(int'(pend_addr));
      committed[pend_addr] = 1'b1;
      pend_valid = 1'b0;
    end
    found = 1'b0;
    if (g >= next_free) begin
      for (int i = 0; i < NC; i++) begin
        ch = (ptr + i) % NC;
        if (!found && (rv[ch] || wv[ch]) && !(g == mask_due && ch == mask_ch)) begin
          found  = 1'b1;
          e.ch   = ch;
          e.wr   = !rv[ch];
          e.due  = g + LAT;
          e.data = e.wr ? '0 : model_mem[raddr[ch]];
          exp_q.push_back(e);
          if (e.wr) begin
            pend_valid = 1'b1; pend_due = g + LAT;
            pend_addr = waddr[ch]; pend_data = wdata[ch];
          end
          ptr = (ch + 1) % NC;
          next_free = g + LAT + 2;
          mask_ch = ch; mask_due = g + LAT + 2;
          busy_from = g; busy_to = g + LAT;
          grant_count++;
        end
      end
    end
  endtask

  task automatic check_output();
    int              k;
    exp_t            e;
    logic [NC-1:0]   er, ew;
    logic [NC*DW-1:0] ebus;
    logic            eb;
    k  = edge_count;
    er = '0;
    ew = '0;
    if (reset_edges.exists(k)) for (int c = 0; c < NC; c++) held[c] = '0;
    if (exp_q.size() > 0 && exp_q[0].due <= k) begin
      e = exp_q.pop_front();
      if (e.due < k) begin
        checks++; errors++;
        $display("[TB] FAIL ready_missing: ch %0d got no ready, required at edge %0d (now %0d)", e.ch, e.due, k);
      end else if (e.wr) begin
        ew[e.ch] = 1'b1;
      end else begin
        er[e.ch] = 1'b1;
        held[e.ch] = e.data;
      end
    end
    checks++;
    if (mem_read_ready !== er || mem_write_ready !== ew) begin
      errors++;
      $display("[TB] FAIL ready_pulse @%0d: got rd %b wr %b, required rd %b wr %b", k, mem_read_ready, mem_write_ready, er, ew);
    end
    eb = (k >= busy_from && k <= busy_to);
    checks++;
    if (busy !== eb) begin
      errors++;
      $display("[TB] FAIL busy @%0d: got %b, required %b", k, busy, eb);
    end
    for (int c = 0; c < NC; c++) ebus[c*DW +: DW] = held[c];
    checks++;
    if (mem_read_data !== ebus) begin
      errors++;
      $display("[TB] FAIL read_data @%0d: got %h, required %h", k, mem_read_data, ebus);
    end
  endtask

  always @(negedge clk) if (edge_count >= 1) check_output();

  // One clock: LSUs sample ready at the edge and drop the matching valid afterwards.
  task automatic tick();
    logic [NC-1:0] sr, sw;
    @(negedge clk);
    sr = mem_read_ready;
    sw = mem_write_ready;
    @(posedge clk);
    #1;
    for (int c = 0; c < NC; c++) begin
      if (sr[c] === 1'b1 && !persist[c]) rv[c] = 1'b0;
      if (sw[c] === 1'b1 && !persist[c]) wv[c] = 1'b0;
    end
  endtask

  task automatic clear_requests();
    for (int c = 0; c < NC; c++) begin
      rv[c] = 1'b0; wv[c] = 1'b0; persist[c] = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    clear_requests();
    apply_stimulus();
    repeat (n - 1) begin tick(); apply_stimulus(); end
    tick();
    reset = 1'b0;
    apply_stimulus();
  endtask

  task automatic run_until_idle(input int max_cycles);
    int n;
    bit pending;
    n = 0;
    pending = 1'b1;
    while (pending && n < max_cycles) begin
      tick();
      apply_stimulus();
      n++;
      pending = (exp_q.size() > 0);
      for (int c = 0; c < NC; c++) if (rv[c] || wv[c]) pending = 1'b1;
    end
    checks++;
    if (pending) begin
      errors++;
      $display("[TB] FAIL idle_timeout: requests still open after %0d cycles, required none", max_cycles);
    end
  endtask

  task automatic check_held(input string name, input int ch, input logic [DW-1:0] want);
    checks++;
    if (mem_read_data[ch*DW +: DW] !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, mem_read_data[ch*DW +: DW], want);
    end
  endtask

  initial begin
    int g0, n;
    for (int c = 0; c < NC; c++) begin
      raddr[c] = '0; waddr[c] = '0; wdata[c] = '0; held[c] = '0;
    end
    do_reset(3);

    // Single write then read from another channel.
    tick(); wv[0] = 1'b1; waddr[0] = 8'h10; wdata[0] = 16'hBEEF; apply_stimulus();
    run_until_idle(50);
    tick(); rv[2] = 1'b1; raddr[2] = 8'h10; apply_stimulus();
    run_until_idle(50);
    check_held("write_then_read", 2, 16'hBEEF);

    // Read and write pending together on one channel: read goes first.
    tick(); wv[2] = 1'b1; waddr[2] = 8'h05; wdata[2] = 16'h0A0A; apply_stimulus();
    run_until_idle(50);
    tick();
    rv[2] = 1'b1; raddr[2] = 8'h05;
    wv[2] = 1'b1; waddr[2] = 8'h05; wdata[2] = 16'h1234;
    apply_stimulus();
    run_until_idle(60);
    check_held("read_before_write", 2, 16'h0A0A);
    tick(); rv[2] = 1'b1; raddr[2] = 8'h05; apply_stimulus();
    run_until_idle(50);
    check_held("read_after_write", 2, 16'h1234);

    // Four-way contention straight out of reset.
    do_reset(2);
    tick();
    for (int c = 0; c < NC; c++) begin
      rv[c] = 1'b1; raddr[c] = (c % 2 == 0) ? 8'h10 : 8'h05;
    end
    apply_stimulus();
    run_until_idle(100);

    // Persistent valids: one channel alone, then two channels alternating.
    tick(); persist[1] = 1'b1; rv[1] = 1'b1; raddr[1] = 8'h10; apply_stimulus();
    repeat (15) begin tick(); apply_stimulus(); end
    tick(); persist[3] = 1'b1; rv[3] = 1'b1; raddr[3] = 8'h05; apply_stimulus();
    repeat (30) begin tick(); apply_stimulus(); end
    tick(); persist[1] = 1'b0; persist[3] = 1'b0; apply_stimulus();
    run_until_idle(60);

    // Reset one cycle after a write grant leaves the old word in place.
    tick(); wv[0] = 1'b1; waddr[0] = 8'h20; wdata[0] = 16'h1111; apply_stimulus();
    run_until_idle(50);
    g0 = grant_count;
    tick(); wv[1] = 1'b1; waddr[1] = 8'h20; wdata[1] = 16'h2222; apply_stimulus();
    n = 0;
    while (grant_count == g0 && n < 20) begin tick(); apply_stimulus(); n++; end
    tick(); reset = 1'b1; clear_requests(); apply_stimulus();
    tick();
    checks++;
    if (mem_read_ready !== '0 || mem_write_ready !== '0 || busy !== 1'b0 || mem_read_data !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got rd %b wr %b busy %b data %h, required all zero",
               mem_read_ready, mem_write_ready, busy, mem_read_data);
    end
    reset = 1'b0; apply_stimulus();
    tick(); rv[3] = 1'b1; raddr[3] = 8'h20; apply_stimulus();
    run_until_idle(50);
    check_held("reset_abort_write", 3, 16'h1111);

    // Random traffic with occasional resets.
    for (int cyc = 0; cyc < 2500; cyc++) begin
      tick();
      if (reset) begin
        reset = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        clear_requests();
      end else begin
        for (int c = 0; c < NC; c++) begin
          if (!rv[c] && known_q.size() > 0 && $urandom_range(0, 7) == 0) begin
            rv[c] = 1'b1;
            raddr[c] = AW'(known_q[$urandom_range(0, known_q.size() - 1)]);
          end
          if (!wv[c] && $urandom_range(0, 9) == 0) begin
            wv[c] = 1'b1;
            waddr[c] = AW'($urandom_range(0, 15));
            wdata[c] = DW'($urandom);
          end
        end
      end
      apply_stimulus();
    end
    if (reset) begin tick(); reset = 1'b0; apply_stimulus(); end
    run_until_idle(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/data_memory_controller.md
# data_memory_controller

Memory-side responder for the per-thread load-store units. It accepts read and write requests from `NUM_CHANNELS` LSU channels and arbitrates between them round-robin, one access at a time. Each access is serviced against an internal data memory with a fixed, parameterised latency, and completion is signalled with a one-cycle ready pulse. It sits between the LSUs of all cores and the data memory, closing the valid/ready handshake that the LSUs initiate.

## Interface
- `NUM_CHANNELS`, 4: number of LSU request channels.
- `ADDR_WIDTH`, 8: data memory address width; memory depth is 2^ADDR_WIDTH words.
- `DATA_WIDTH`, 16: data word width.
- `LATENCY`, 2: cycles from grant to ready pulse; legal values are 1 to 15.
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high reset.
- `mem_read_valid` input NUM_CHANNELS: per-channel read request; held high until ready is seen.
- `mem_read_address` input NUM_CHANNELS*ADDR_WIDTH: per-channel read address; channel c occupies slice [c*ADDR_WIDTH +: ADDR_WIDTH].
- `mem_read_ready` output NUM_CHANNELS: per-channel one-cycle read completion pulse.
- `mem_read_data` output NUM_CHANNELS*DATA_WIDTH: per-channel read data; valid while ready is high and held afterwards.
- `mem_write_valid` input NUM_CHANNELS: per-channel write request.
- `mem_write_address` input NUM_CHANNELS*ADDR_WIDTH: per-channel write address.
- `mem_write_data` input NUM_CHANNELS*DATA_WIDTH: per-channel write data.
- `mem_write_ready` output NUM_CHANNELS: per-channel one-cycle write completion pulse.
- `busy` output 1: high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, ACCESS, RESPOND.
- **IDLE**
  - A channel is eligible when it has read or write valid high and is not masked.
  - The controller scans channels starting at `rr_ptr`, wrapping modulo NUM_CHANNELS, and grants the first eligible one.
  - On grant it latches the channel index, operation, address and write data, loads `count = LATENCY-1`, and moves to ACCESS.
  - `rr_ptr` becomes granted index + 1, wrapping at NUM_CHANNELS.
  - If no channel is eligible, it stays in IDLE.
- **Operation choice on a granted channel:** read has priority if both read and write valid are high. The write stays pending and competes in a later arbitration round.
- **ACCESS**
  - While `count != 0`, it decrements `count` each cycle.
  - When `count == 0`, it performs the access:
    - Read: `mem_read_data[c] <= mem[addr]`, `mem_read_ready[c] <= 1`.
    - Write: `mem[addr] <= data`, `mem_write_ready[c] <= 1`.
  - It then moves to RESPOND.
- **RESPOND**
  - Clears all ready bits and returns to IDLE.
  - Channel c is masked for this single arbitration cycle, because its valid is still visible on the edge at which it samples ready.
  - The mask applies only in the cycle immediately following RESPOND.
- **Latched values:** address and data are captured at grant. Changes on request inputs after grant are ignored.
- **Held read data:** `mem_read_data[c]` holds its last value until the next read completion on channel c.
- **Addressing:** addresses are used unmodified; there is no wrap or bounds logic.
- **Memory contents:** not reset. A read of a never-written word returns X in simulation.

## Timing
- **Reset values:** all `mem_read_ready`, `mem_write_ready`, and `mem_read_data` are 0; `busy` is 0; state is IDLE; `rr_ptr` is 0; mask is cleared.
- **Latency:** if the grant occurs at edge E, ready is high in the cycle after edge E+LATENCY and is low again after edge E+LATENCY+1.
- **Throughput:** the earliest next grant is at edge E+LATENCY+2, giving at most one access per LATENCY+2 cycles.
- **Pulse width:** exactly one cycle per request; ready never asserts for an ungranted channel.
- **Simultaneous requests:** serviced in round-robin order from `rr_ptr`. No channel waits more than NUM_CHANNELS grants once its valid is high.
- **Reset mid-operation:** the transaction is abandoned with no ready pulse. A write not yet at its ACCESS `count == 0` edge does not modify memory.
- **Persistent valid:** a valid that stays high after its own ready (a protocol violation) is re-granted as a new request after the mask cycle.

## Test plan
- **Single write then read.** Set LATENCY=2 and drive channel 0 write valid with addr 0x10, data 0xBEEF.
  - `mem_write_ready[0]` pulses exactly 2 cycles after grant.
  - A subsequent read of 0x10 on channel 2 returns 0xBEEF with `mem_read_ready[2]` as a single one-cycle pulse.
- **Four-way contention.** After reset, all 4 channels raise read valid in the same cycle.
  - Grants occur in order 0, 1, 2, 3, spaced LATENCY+2 cycles apart.
  - `busy` stays high throughout except for single IDLE cycles.
- **Round-robin fairness.** Channels 1 and 3 hold valid continuously and re-request immediately after each ready.
  - Grants alternate 1, 3, 1, 3.
  - The mask prevents a double grant of the same channel on its own ready edge.
- **Read/write on the same channel.** Channel 2 raises read addr 0x05 and write addr 0x05 data 0x1234 simultaneously, with memory[0x05] = 0x0A0A.
  - The read is served first and returns 0x0A0A.
  - The write is served next.
  - A later read returns 0x1234.
- **Reset mid-access.** Set LATENCY=3 and assert reset one cycle after a write grant to addr 0x20, which previously held 0x1111.
  - No ready pulse occurs and all outputs are 0.
  - A read of 0x20 after reset returns 0x1111.
- **Minimum latency.** Set LATENCY=1 and issue back-to-back reads from one channel.
  - Ready appears 1 cycle after grant.
  - The next grant occurs 3 cycles after the previous grant.
